// File: rtl/lcd_timing_gen.sv
// Parametrised LVDS panel timing and test-pattern generator, one-cycle registered output.
// Optional macro LCD_TPG_SCROLL_EN: ramp and checker patterns scroll one pixel per frame.
module lcd_timing_gen #(
  parameter int unsigned H_ACTIVE   = 1366,
  parameter int unsigned H_FP       = 30,
  parameter int unsigned H_SYNC     = 114,
  parameter int unsigned H_BP       = 30,
  parameter int unsigned V_ACTIVE   = 768,
  parameter int unsigned V_FP       = 3,
  parameter int unsigned V_SYNC     = 5,
  parameter int unsigned V_BP       = 4,
  parameter bit          SYNC_POL   = 1'b1,
  parameter int unsigned BPC        = 6,
  parameter int unsigned CW         = 12,
  parameter int unsigned RAMP_SHIFT = 4,
  parameter int unsigned CHK_LOG2   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [2:0]         mode,
  input  logic [3*BPC-1:0]   solid_rgb,
  output logic [3*BPC+2:0]   video_data,
  output logic               de,
  output logic               hsync,
  output logic               vsync,
  output logic [CW-1:0]      pos_x,
  output logic [CW-1:0]      pos_y,
  output logic               frame_start,
  output logic [15:0]        frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] BAR1   = CW'(H_ACTIVE / 4);
  localparam logic [CW-1:0] BAR2   = CW'(2 * (H_ACTIVE / 4));
  localparam logic [CW-1:0] BAR3   = CW'(3 * (H_ACTIVE / 4));

  typedef enum logic [2:0] {
    PAT_BARS   = 3'd0,
    PAT_RAMP   = 3'd1,
    PAT_CHECK  = 3'd2,
    PAT_SOLID  = 3'd3,
    PAT_BLACK4 = 3'd4,
    PAT_BLACK5 = 3'd5,
    PAT_BLACK6 = 3'd6,
    PAT_BLACK7 = 3'd7
  } pat_e;

  logic [CW-1:0]    h_q, h_d, v_q, v_d;
  logic [CW-1:0]    pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  pat_e             mode_q, mode_d, mode_eff;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
  logic [3*BPC-1:0] rgb_q, rgb_d, pat_rgb;
  logic [CW-1:0]    x_eff;
  logic [BPC-1:0]   grey;
  logic             at_origin, active;

  // Pixel (0,0) already uses the incoming mode so the whole frame is consistent.
  always_comb begin
    at_origin = (h_q == '0) && (v_q == '0);
    mode_eff  = at_origin ? pat_e'(mode) : mode_q;
`ifdef LCD_TPG_SCROLL_EN
    x_eff = h_q + frame_cnt_q[CW-1:0];
`else
    x_eff = h_q;
`endif
    grey    = BPC'(x_eff >> RAMP_SHIFT);
    pat_rgb = '0;
    case (mode_eff)
      PAT_BARS: begin
        if (h_q < BAR1)      pat_rgb = {{BPC{1'b0}}, {BPC{1'b1}}, {BPC{1'b0}}};
        else if (h_q < BAR2) pat_rgb = {{BPC{1'b1}}, {BPC{1'b0}}, {BPC{1'b0}}};
        else if (h_q < BAR3) pat_rgb = {{BPC{1'b0}}, {BPC{1'b0}}, {BPC{1'b1}}};
        else                 pat_rgb = '1;
      end
      PAT_RAMP:  pat_rgb = {grey, grey, grey};
      PAT_CHECK: if (x_eff[CHK_LOG2] ^ v_q[CHK_LOG2]) pat_rgb = '1;
      PAT_SOLID: pat_rgb = solid_rgb;
      default:   pat_rgb = '0;
    endcase
  end

  always_comb begin
    h_d         = h_q;
    v_d         = v_q;
    mode_d      = mode_q;
    frame_cnt_d = frame_cnt_q;
    active      = (h_q < H_ACT) && (v_q < V_ACT);
    de_d        = 1'b0;
    hs_d        = ~SYNC_POL;
    vs_d        = ~SYNC_POL;
    fs_d        = 1'b0;
    rgb_d       = '0;
    pos_x_d     = '0;
    pos_y_d     = '0;
    if (enable) begin
      if (at_origin) mode_d = mode_eff;
      if (h_q == H_LAST) begin
        h_d = '0;
        if (v_q == V_LAST) begin
          v_d         = '0;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
          v_d = v_q + CW'(1);
        end
      end else begin
        h_d = h_q + CW'(1);
      end
      de_d    = active;
      hs_d    = ((h_q >= HS_BEG) && (h_q < HS_END)) ? SYNC_POL : ~SYNC_POL;
      vs_d    = ((v_q >= VS_BEG) && (v_q < VS_END)) ? SYNC_POL : ~SYNC_POL;
      fs_d    = at_origin;
      rgb_d   = active ? pat_rgb : '0;
      pos_x_d = h_q;
      pos_y_d = v_q;
    end else begin
      h_d = '0;
      v_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q         <= '0;
      v_q         <= '0;
      mode_q      <= PAT_BARS;
      frame_cnt_q <= '0;
      de_q        <= 1'b0;
      hs_q        <= ~SYNC_POL;
      vs_q        <= ~SYNC_POL;
      fs_q        <= 1'b0;
      rgb_q       <= '0;
      pos_x_q     <= '0;
      pos_y_q     <= '0;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      mode_q      <= mode_d;
      frame_cnt_q <= frame_cnt_d;
      de_q        <= de_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      fs_q        <= fs_d;
      rgb_q       <= rgb_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
    end
  end

  assign video_data  = {hs_q, vs_q, de_q, rgb_q};
  assign de          = de_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign pos_x       = pos_x_q;
  assign pos_y       = pos_y_q;
  assign frame_start = fs_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Randomised bench for lcd_timing_gen on a reduced raster, checked against a
// pixel-count reference model of the timing and pattern rules.
`timescale 1ns/1ps
module tb_lcd_timing_gen;

  localparam int HA = 42, HFP = 3, HSW = 5, HBP = 4;
  localparam int VA = 20, VFP = 2, VSW = 3, VBP = 2;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam bit POL = 1'b0;
  localparam int BPC = 6, CW = 8, RS = 1, CL = 2;
  localparam int VW = 3 * BPC + 3;
  localparam int BW = VW + 2 * CW + 1 + 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic [2:0]       mode = 3'd0;
  logic [3*BPC-1:0] solid_rgb = '0;
  logic [VW-1:0]    video_data;
  logic             de, hsync, vsync, frame_start;
  logic [CW-1:0]    pos_x, pos_y;
  logic [15:0]      frame_cnt;
  logic [BW-1:0]    dut_b;

  int          total = 0, bad = 0;
  int          n = 0, fmode = 0, last_x = -1, last_y = -1;
  logic [15:0] fc = '0;

  assign dut_b = {video_data, pos_x, pos_y, frame_start, frame_cnt};

  always #5 clk = ~clk;

  lcd_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .SYNC_POL(POL), .BPC(BPC), .CW(CW), .RAMP_SHIFT(RS), .CHK_LOG2(CL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .solid_rgb(solid_rgb),
    .video_data(video_data), .de(de), .hsync(hsync), .vsync(vsync),
    .pos_x(pos_x), .pos_y(pos_y), .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  function automatic logic [VW-1:0] model_video(int x, int y, int m, logic [15:0] k,
                                                logic [3*BPC-1:0] solid);
    int  xe, r, g, b, q, mx;
    logic d, hs, vs;
    mx = (1 << BPC) - 1;
    q  = HA / 4;
    r = 0; g = 0; b = 0;
    d  = (x < HA) && (y < VA);
    hs = (x >= HA + HFP && x < HA + HFP + HSW) ? POL : ~POL;
    vs = (y >= VA + VFP && y < VA + VFP + VSW) ? POL : ~POL;
    xe = x;
`ifdef LCD_TPG_SCROLL_EN
    if (m == 1 || m == 2) xe = (x + int'(k)) % (1 << CW);
`endif
    case (m)
      0: begin
        if (x < q) r = mx;
        else if (x < 2 * q) g = mx;
        else if (x < 3 * q) b = mx;
        else begin r = mx; g = mx; b = mx; end
      end
      1: begin r = (xe >> RS) % (mx + 1); g = r; b = r; end
      2: if ((((xe >> CL) & 1) ^ ((y >> CL) & 1)) != 0) begin r = mx; g = mx; b = mx; end
      3: begin
        g = int'(solid[3*BPC-1:2*BPC]);
        r = int'(solid[2*BPC-1:BPC]);
        b = int'(solid[BPC-1:0]);
      end
      default: ;
    endcase
    if (!d) begin r = 0; g = 0; b = 0; end
    return {hs, vs, d, BPC'(g), BPC'(r), BPC'(b)};
  endfunction

  function automatic logic [BW-1:0] idle_bundle(logic [15:0] k);
    return {~POL, ~POL, 1'b0, {3*BPC{1'b0}}, {2*CW{1'b0}}, 1'b0, k};
  endfunction

  // Advance one clock and produce the expected output bundle for it.
  task automatic tick(output logic [BW-1:0] e);
    int x, y;
    logic [VW-1:0] vw;
    logic fs;
    @(posedge clk);
    if (enable) begin
      x  = n % HT;
      y  = (n / HT) % VT;
      fs = (x == 0 && y == 0);
      if (fs) fmode = int'(mode);
      vw = model_video(x, y, fmode, fc, solid_rgb);
      if (x == HT - 1 && y == VT - 1) fc = fc + 16'd1;
      n++;
      e = {vw, CW'(x), CW'(y), fs, fc};
      last_x = x;
      last_y = y;
    end else begin
      n = 0;
      e = idle_bundle(fc);
      last_x = -1;
      last_y = -1;
    end
    #1;
  endtask

  task automatic test_reset();
    logic [BW-1:0] e;
    rst_n = 1'b0; enable = 1'b1; mode = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    e = idle_bundle(16'd0);
    total++;
    if (dut_b !== e) begin bad++; $display("FAIL reset_bundle: got=%h exp=%h", dut_b, e); end
    total++;
    if ({de, hsync, vsync} !== {1'b0, ~POL, ~POL}) begin
      bad++; $display("FAIL reset_ctrl: got=%b exp=%b", {de, hsync, vsync}, {1'b0, ~POL, ~POL});
    end
    n = 0; fc = '0; fmode = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_bars();
    logic [BW-1:0] e;
    mode = 3'd0;
    for (int c = 0; c <= HT * VT; c++) begin
      tick(e);
      total++;
      if (dut_b !== e) begin bad++; $display("FAIL bars c=%0d: got=%h exp=%h", c, dut_b, e); end
      total++;
      if ({hsync, vsync, de} !== e[BW-1 -: 3]) begin
        bad++; $display("FAIL ctrl_copies c=%0d: got=%b exp=%b", c, {hsync, vsync, de}, e[BW-1 -: 3]);
      end
      if (c == 0) begin
        total++;
        if ({frame_start, de, video_data[3*BPC-1:0]} !== {1'b1, 1'b1, 6'd0, 6'd63, 6'd0}) begin
          bad++; $display("FAIL first_pixel: got=%h exp=%h",
                          {frame_start, de, video_data[3*BPC-1:0]}, {1'b1, 1'b1, 6'd0, 6'd63, 6'd0});
        end
      end
    end
  endtask

  task automatic test_frame_period();
    logic [BW-1:0] e;
    int cnt = 0;
    bit found = 0;
    for (int c = 0; c < 2 * HT * VT && !found; c++) begin
      tick(e);
      total++;
      if (dut_b !== e) begin bad++; $display("FAIL period_seek: got=%h exp=%h", dut_b, e); end
      if (frame_start) found = 1;
    end
    found = 0;
    for (int c = 0; c < 2 * HT * VT && !found; c++) begin
      tick(e);
      cnt++;
      total++;
      if (dut_b !== e) begin bad++; $display("FAIL period_run: got=%h exp=%h", dut_b, e); end
      if (frame_start) found = 1;
    end
    total++;
    if (!found || cnt != HT * VT) begin
      bad++; $display("FAIL frame_period: got=%0d exp=%0d", cnt, HT * VT);
    end
  endtask

  task automatic test_mode_change();
    logic [BW-1:0] e;
    bit hit = 0;
    for (int c = 0; c < 2 * HT * VT && !hit; c++) begin
      tick(e);
      total++;
      if (dut_b !== e) begin bad++; $display("FAIL mode_seek: got=%h exp=%h", dut_b, e); end
      if (last_x == 7 && last_y == 5) hit = 1;
    end
    total++;
    if (!hit) begin bad++; $display("FAIL mode_seek_timeout: got=%0d exp=1", hit); end
    mode = 3'd3;
    solid_rgb = {6'd1, 6'd2, 6'd3};
    for (int c = 0; c < 2 * HT * VT; c++) begin
      tick(e);
      total++;
      if (dut_b !== e) begin bad++; $display("FAIL mode_change: got=%h exp=%h", dut_b, e); end
      if (frame_start) begin
        total++;
        if (video_data[3*BPC-1:0] !== {6'd1, 6'd2, 6'd3}) begin
          bad++; $display("FAIL solid_first: got=%h exp=%h", video_data[3*BPC-1:0], {6'd1, 6'd2, 6'd3});
        end
      end
    end
  endtask

  task automatic test_enable_drop(input int tx, input int ty);
    logic [BW-1:0] e;
    logic [15:0] held;
    bit hit = 0;
    for (int c = 0; c < 2 * HT * VT && !hit; c++) begin
      tick(e);
      total++;
      if (dut_b !== e) begin bad++; $display("FAIL drop_seek: got=%h exp=%h", dut_b, e); end
      if (last_x == tx && last_y == ty) hit = 1;
    end
    total++;
    if (!hit) begin bad++; $display("FAIL drop_seek_timeout: got=%0d exp=1", hit); end
    held = fc;
    enable = 1'b0;
    repeat ($urandom_range(1, 20)) begin
      tick(e);
      total++;
      if (dut_b !== e) begin bad++; $display("FAIL drop_idle: got=%h exp=%h", dut_b, e); end
      total++;
      if ({de, hsync, vsync, frame_cnt} !== {1'b0, ~POL, ~POL, held}) begin
        bad++; $display("FAIL drop_hold: got=%h exp=%h", {de, hsync, vsync, frame_cnt}, {1'b0, ~POL, ~POL, held});
      end
    end
    enable = 1'b1;
    tick(e);
    total++;
    if ({frame_start, pos_x, pos_y} !== {1'b1, {2*CW{1'b0}}}) begin
      bad++; $display("FAIL restart_origin: got=%h exp=%h", {frame_start, pos_x, pos_y}, {1'b1, {2*CW{1'b0}}});
    end
    for (int c = 0; c < HT * 3; c++) begin
      tick(e);
      total++;
      if (dut_b !== e) begin bad++; $display("FAIL drop_resume: got=%h exp=%h", dut_b, e); end
    end
  endtask

  task automatic test_scroll();
    logic [BW-1:0] e;
    for (int sel = 1; sel <= 2; sel++) begin
      mode = 3'(sel);
      for (int c = 0; c < 2 * HT * VT; c++) begin
        tick(e);
        total++;
        if (dut_b !== e) begin bad++; $display("FAIL scroll m=%0d: got=%h exp=%h", sel, dut_b, e); end
      end
    end
  endtask

  task automatic test_random();
    logic [BW-1:0] e;
    for (int c = 0; c < 6000; c++) begin
      tick(e);
      total++;
      if (dut_b !== e) begin bad++; $display("FAIL random c=%0d: got=%h exp=%h", c, dut_b, e); end
      if ($urandom_range(0, 299) == 0) mode = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) solid_rgb = (3*BPC)'($urandom);
      if (enable && $urandom_range(0, 399) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
    end
    enable = 1'b1;
  endtask

  task automatic test_midframe_reset();
    logic [BW-1:0] e;
    repeat ($urandom_range(100, 1000)) begin
      tick(e);
      total++;
      if (dut_b !== e) begin bad++; $display("FAIL prereset: got=%h exp=%h", dut_b, e); end
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    e = idle_bundle(16'd0);
    total++;
    if (dut_b !== e) begin bad++; $display("FAIL async_reset: got=%h exp=%h", dut_b, e); end
    n = 0; fc = '0; fmode = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < HT * VT + 10; c++) begin
      tick(e);
      total++;
      if (dut_b !== e) begin bad++; $display("FAIL post_reset: got=%h exp=%h", dut_b, e); end
    end
  endtask

  initial begin
    test_reset();
    test_bars();
    test_frame_period();
    test_mode_change();
    test_enable_drop(HA - 2, 10);
    test_enable_drop($urandom_range(0, HT - 1), $urandom_range(0, VT - 1));
    test_scroll();
    test_random();
    test_midframe_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_timing_gen.md
# lcd_timing_gen

Parametrised LVDS panel timing and test-pattern generator, clocked by the pixel clock. It produces the packed video word {hsync, vsync, de, G, R, B} consumed by the 7:1 serialiser's `datain`. It generalises the fixed 1366x768 stripe generator: timing, polarity and colour depth are set by parameters, and the pattern source is run-time selectable. Mode changes are frame-synchronous.

## Interface
Parameters:
- `H_ACTIVE`, 1366, visible pixels per line
- `H_FP`, 30, horizontal front porch (pixels)
- `H_SYNC`, 114, hsync pulse width (pixels)
- `H_BP`, 30, horizontal back porch (pixels)
- `V_ACTIVE`, 768, visible lines
- `V_FP`, 3, vertical front porch (lines)
- `V_SYNC`, 5, vsync pulse width (lines)
- `V_BP`, 4, vertical back porch (lines)
- `SYNC_POL`, 1, active level of hsync/vsync
- `BPC`, 6, bits per colour channel
- `CW`, 12, position counter width; must satisfy 2^CW > H_TOTAL and 2^CW > V_TOTAL
- `RAMP_SHIFT`, 4, grey-ramp divisor exponent
- `CHK_LOG2`, 5, checker square size exponent (32 px)

Ports:
- `clk`  in  1  pixel clock
- `rst_n`  in  1  asynchronous active-low reset
- `enable`  in  1  run timing; low holds the generator idle
- `mode`  in  3  pattern select, latched at frame start
- `solid_rgb`  in  3*BPC  {G,R,B} colour for solid mode
- `video_data`  out  3*BPC+3  {hsync, vsync, de, G, R, B}
- `de`, `hsync`, `vsync`  out  1 each  copies of the `video_data` control bits
- `pos_x`, `pos_y`  out  CW each  position of the pixel currently on `video_data`
- `frame_start`  out  1  one-cycle pulse accompanying pixel (0,0)
- `frame_cnt`  out  16  completed-frame counter, wraps

## Operation
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1540); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 780).
- Internal counters `h` (0..H_TOTAL-1) and `v` (0..V_TOTAL-1):
  - `h` increments every cycle while `enable` is high.
  - At H_TOTAL-1, `h` wraps to 0 and `v` increments.
  - At (H_TOTAL-1, V_TOTAL-1), `v` wraps to 0.
- `de` = (h < H_ACTIVE) && (v < V_ACTIVE).
- `hsync` = SYNC_POL when H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC, else ~SYNC_POL.
- `vsync` = SYNC_POL for whole lines V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC. The level changes at h=0 of the line.
- Mode shadow: `mode` is copied into `mode_q` only when h=0 and v=0. A mid-frame change therefore takes effect on the next frame.
- Pattern, evaluated with x=h, y=v (x_eff defined under Configuration):
  - 0, colour bars: quarters of H_ACTIVE (integer division) are red, green, blue, white, each at full scale (2^BPC-1).
  - 1, grey ramp: each channel = (x_eff >> RAMP_SHIFT) truncated to BPC bits, so the ramp wraps.
  - 2, checker: white when x_eff[CHK_LOG2] ^ y[CHK_LOG2], otherwise black.
  - 3, solid: `solid_rgb`.
  - 4–7: black.
- RGB is forced to 0 whenever `de`=0.
- `frame_cnt` increments, wrapping, when (h,v) wraps from the last pixel to (0,0).
- `enable` low:
  - Next cycle: h=v=0, `de`=0, syncs at ~SYNC_POL, RGB=0, `frame_start`=0.
  - `frame_cnt` and `mode_q` are held.
  - On re-enable, the first output pixel is (0,0) and `frame_start` pulses.

## Timing
- Every output is registered. Counter state (h,v) at cycle n appears on the outputs at cycle n+1, together with `pos_x`=h and `pos_y`=v.
- Latency is fixed: 1 cycle from counter to `video_data`. No back-pressure.
- Reset values (asynchronous, all outputs):
  - `video_data` = {~SYNC_POL, ~SYNC_POL, 0, 0…}
  - `de`=0, `hsync`=`vsync`=~SYNC_POL
  - `pos_x`=`pos_y`=0, `frame_start`=0, `frame_cnt`=0
  - internal `mode_q`=0, h=v=0
- After `rst_n` rises with `enable`=1, the first clock edge outputs pixel (0,0) with `frame_start`=1 and `de`=1.
- Reset asserted mid-frame clears immediately. No partial-frame count is kept.
- Frame period is exactly H_TOTAL*V_TOTAL cycles (1 201 200 at default parameters).

## Configuration
- Macro `LCD_TPG_SCROLL_EN`.
- When defined: for modes 1 and 2, x_eff = (h + frame_cnt[CW-1:0]) mod 2^CW, so the pattern scrolls one pixel per frame. Modes 0 and 3 are unaffected.
- When undefined: x_eff = h. No adder is instantiated.

## Test plan
- Reset, enable=1, mode=0, defaults → first output (0,0) with de=1 and frame_start=1. Pixel 0 is R=63, G=0, B=0; pixel 341 is green; pixel 1365 is white; pixel 1366 has de=0 and RGB=0.
- Horizontal sync → hsync asserts (level 1) at pos_x=1396 and deasserts at pos_x=1510, every line. vsync is high for pos_y 771–775 and low elsewhere.
- Frame period → successive frame_start pulses are 1 201 200 cycles apart; frame_cnt goes 0→1→2.
- Mode change mid-frame (mode 0→3 at pos_y=100, solid_rgb={6'd1,6'd2,6'd3}) → the rest of the frame stays colour bars. The next frame is solid, with G=1, R=2, B=3 at every active pixel.
- enable dropped at pos_x=500, pos_y=10 → next cycle de=0, syncs inactive, frame_cnt held. On re-enable, the output restarts at (0,0) with frame_start=1.
- Mode 1 with `LCD_TPG_SCROLL_EN` defined → in frame k (frame_cnt=k), pixel x carries grey ((x+k)>>4)&63. With the macro undefined, the value is (x>>4)&63 in every frame.
